// File: rtl/lpc_io_write_target_if.sv
// LPC pin-side bundle: host-driven LFRAME#/LAD sample and the target's LAD drive.
interface lpc_io_write_target_if;
  logic       LFRAME_n;
  logic [3:0] LadIn;
  logic [3:0] LadOut;
  logic       LadOe;

  modport master (output LFRAME_n, LadIn, input LadOut, LadOe);
  modport slave  (input LFRAME_n, LadIn, output LadOut, LadOe);
endinterface

// File: rtl/lpc_io_write_target.sv
// LPC I/O-write target for the CPLD register window: decodes host writes,
// returns SYNC and holds the 32-byte register image read by the data mux.
module lpc_io_write_target #(
  parameter logic [15:0] BASE_ADDR  = 16'h0800,
  parameter logic [7:0]  HW_VERSION = 8'h01
) (
  input  logic                  PciReset,
  input  logic                  LpcClock,
  lpc_io_write_target_if.slave  lpc,
  output logic [7:0]            AddrReg,
  output logic [7:0]            DataWr,
  output logic                  WrStrobe,
  output logic [7:0]            DataReg [32]
);

  localparam int unsigned REG_COUNT = 32;

  typedef enum logic [3:0] {
    IDLE, CYC, ADDR, DATA_LO, DATA_HI, TAR_H1, TAR_H2, SYNC, TAR_P1, TAR_P2
  } state_t;

  state_t      state;
  logic [1:0]  nibCnt;
  logic [11:0] addr;
  logic [7:0]  data;
  logic [7:0]  regFile [REG_COUNT-1:1];
  logic [15:0] addrNext;

  // Address as it will look once the current nibble is shifted in.
  assign addrNext = {addr, lpc.LadIn};

  // Entry 0 is the read-only version byte; the rest come from the flops.
  always_comb begin
    DataReg[0] = HW_VERSION;
    for (int i = 1; i < REG_COUNT; i++) DataReg[i] = regFile[i];
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      state      <= IDLE;
      nibCnt     <= 2'd0;
      addr       <= 12'h000;
      data       <= 8'h00;
      lpc.LadOut <= 4'hF;
      lpc.LadOe  <= 1'b0;
      WrStrobe   <= 1'b0;
      AddrReg    <= 8'h00;
      DataWr     <= 8'h00;
      for (int i = 1; i < REG_COUNT; i++) regFile[i] <= 8'h00;
    end else begin
      WrStrobe <= 1'b0;
      // LFRAME# low restarts or aborts whatever is in flight, commit included.
      if (!lpc.LFRAME_n) begin
        state      <= (lpc.LadIn == 4'h0) ? CYC : IDLE;
        lpc.LadOe  <= 1'b0;
        lpc.LadOut <= 4'hF;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          CYC: begin
            if (lpc.LadIn[3:1] == 3'b001) begin
              state  <= ADDR;
              nibCnt <= 2'd0;
            end else begin
              state <= IDLE;
            end
          end
          ADDR: begin
            addr   <= addrNext[11:0];
            nibCnt <= nibCnt + 2'd1;
            if (nibCnt == 2'd3)
              state <= (addrNext[15:5] == BASE_ADDR[15:5]) ? DATA_LO : IDLE;
          end
          DATA_LO: begin
            data[3:0] <= lpc.LadIn;
            state     <= DATA_HI;
          end
          DATA_HI: begin
            data[7:4] <= lpc.LadIn;
            state     <= TAR_H1;
          end
          TAR_H1: state <= TAR_H2;
          TAR_H2: begin
            state      <= SYNC;
            lpc.LadOe  <= 1'b1;
            lpc.LadOut <= 4'h0;
            WrStrobe   <= 1'b1;
          end
          SYNC: begin
            state      <= TAR_P1;
            lpc.LadOut <= 4'hF;
            AddrReg    <= {3'b000, addr[4:0]};
            DataWr     <= data;
            if (addr[4:0] != 5'd0) regFile[addr[4:0]] <= data;
          end
          TAR_P1: begin
            state     <= TAR_P2;
            lpc.LadOe <= 1'b0;
          end
          TAR_P2: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lpc_io_write_target.sv
// Directed LPC write cycles against a scoreboard of expected SYNC/commit events.
module tb_lpc_io_write_target;

  logic       LpcClock = 1'b0;
  logic       PciReset = 1'b0;
  logic [7:0] AddrReg, DataWr;
  logic       WrStrobe;
  logic [7:0] DataReg [32];

  lpc_io_write_target_if bus ();

  lpc_io_write_target dut (
    .PciReset (PciReset),
    .LpcClock (LpcClock),
    .lpc      (bus),
    .AddrReg  (AddrReg),
    .DataWr   (DataWr),
    .WrStrobe (WrStrobe),
    .DataReg  (DataReg)
  );

  always #15 LpcClock = ~LpcClock;

  typedef struct {
    int         syncCyc;
    logic [4:0] off;
    logic [7:0] data;
  } exp_t;

  exp_t       sbQ [$];
  logic [7:0] model [32];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         strobeCnt = 0;
  int         oeCnt = 0;

  always @(posedge LpcClock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each strobe and checks SYNC then TAR_P1.
  bit   postPending = 1'b0;
  exp_t cur;
  always @(negedge LpcClock) begin
    if (PciReset) begin
      if (bus.LadOe) oeCnt++;
      if (WrStrobe) begin
        strobeCnt++;
        if (sbQ.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          cur = sbQ.pop_front();
          check("sync_cycle", 32'(cyc), 32'(cur.syncCyc));
          check("sync_oe", 32'(bus.LadOe), 32'd1);
          check("sync_lad", 32'(bus.LadOut), 32'h0);
          postPending = 1'b1;
        end
      end else if (postPending) begin
        postPending = 1'b0;
        check("tarp1_oe", 32'(bus.LadOe), 32'd1);
        check("tarp1_lad", 32'(bus.LadOut), 32'hF);
        check("commit_addr", 32'(AddrReg), 32'({3'b000, cur.off}));
        check("commit_data", 32'(DataWr), 32'(cur.data));
        check("commit_reg", 32'(DataReg[cur.off]), 32'((cur.off == 5'd0) ? 8'h01 : cur.data));
      end
    end
  end

  task automatic drive(input logic fr, input logic [3:0] nib);
    @(negedge LpcClock);
    bus.LFRAME_n = fr;
    bus.LadIn    = nib;
  endtask

  task automatic checkArray(input string name);
    int mism = 0;
    for (int i = 0; i < 32; i++) if (DataReg[i] !== model[i]) mism++;
    check(name, 32'(mism), 32'd0);
  endtask

  // Full 13-clock cycle; tail < 3 overlaps the next START with TAR_P2.
  task automatic ioCycle(input logic [3:0] ct, input logic [15:0] a, input logic [7:0] d,
                         input bit accept, input int tail);
    exp_t e;
    drive(1'b0, 4'h0);
    if (accept) begin
      e.syncCyc = cyc + 1 + 9;
      e.off     = a[4:0];
      e.data    = d;
      sbQ.push_back(e);
      if (a[4:0] != 5'd0) model[a[4:0]] = d;
    end
    drive(1'b1, ct);
    drive(1'b1, a[15:12]);
    drive(1'b1, a[11:8]);
    drive(1'b1, a[7:4]);
    drive(1'b1, a[3:0]);
    drive(1'b1, d[3:0]);
    drive(1'b1, d[7:4]);
    drive(1'b1, 4'hF);
    drive(1'b1, 4'hF);
    for (int i = 0; i < tail; i++) drive(1'b1, 4'hF);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 4'hF);
  endtask

  int s0, o0;

  initial begin
    bus.LFRAME_n = 1'b1;
    bus.LadIn    = 4'hF;
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    model[0] = 8'h01;

    repeat (3) @(negedge LpcClock);
    check("rst_oe", 32'(bus.LadOe), 32'd0);
    check("rst_lad", 32'(bus.LadOut), 32'hF);
    check("rst_strobe", 32'(WrStrobe), 32'd0);
    check("rst_addr", 32'(AddrReg), 32'h00);
    check("rst_data", 32'(DataWr), 32'h00);
    checkArray("rst_array");
    PciReset = 1'b1;
    idle(2);

    // Write 0x5A to 0x080E
    s0 = strobeCnt; o0 = oeCnt;
    ioCycle(4'h2, 16'h080E, 8'h5A, 1'b1, 3);
    idle(2);
    check("w0e_strobes", 32'(strobeCnt - s0), 32'd1);
    check("w0e_oe_clocks", 32'(oeCnt - o0), 32'd2);
    check("w0e_reg14", 32'(DataReg[14]), 32'h5A);
    checkArray("w0e_array");

    // Write 0xFF to offset 0: acknowledged, version byte untouched
    s0 = strobeCnt; o0 = oeCnt;
    ioCycle(4'h2, 16'h0800, 8'hFF, 1'b1, 3);
    idle(1);
    check("w00_strobes", 32'(strobeCnt - s0), 32'd1);
    check("w00_datawr", 32'(DataWr), 32'hFF);
    check("w00_reg0", 32'(DataReg[0]), 32'h01);
    checkArray("w00_array");

    // Window miss
    s0 = strobeCnt; o0 = oeCnt;
    ioCycle(4'h2, 16'h0820, 8'h33, 1'b0, 3);
    idle(2);
    check("miss_strobes", 32'(strobeCnt - s0), 32'd0);
    check("miss_oe_clocks", 32'(oeCnt - o0), 32'd0);
    checkArray("miss_array");

    // Abort after DATA_LO
    s0 = strobeCnt; o0 = oeCnt;
    drive(1'b0, 4'h0);
    drive(1'b1, 4'h2);
    drive(1'b1, 4'h0); drive(1'b1, 4'h8); drive(1'b1, 4'h0); drive(1'b1, 4'h1);
    drive(1'b1, 4'h7);
    drive(1'b0, 4'hF);
    idle(8);
    check("abort_strobes", 32'(strobeCnt - s0), 32'd0);
    check("abort_oe_clocks", 32'(oeCnt - o0), 32'd0);
    check("abort_reg1", 32'(DataReg[1]), 32'h00);

    // I/O read ignored, immediately followed by a write to the same offset
    s0 = strobeCnt; o0 = oeCnt;
    ioCycle(4'h0, 16'h0801, 8'h99, 1'b0, 3);
    check("read_strobes", 32'(strobeCnt - s0), 32'd0);
    check("read_oe_clocks", 32'(oeCnt - o0), 32'd0);
    ioCycle(4'h2, 16'h0801, 8'hA5, 1'b1, 3);
    idle(1);
    check("rdwr_reg1", 32'(DataReg[1]), 32'hA5);
    checkArray("rdwr_array");

    // START sampled during TAR_P2 of the previous write
    s0 = strobeCnt; o0 = oeCnt;
    ioCycle(4'h2, 16'h0805, 8'h3C, 1'b1, 2);
    ioCycle(4'h2, 16'h0806, 8'hC3, 1'b1, 3);
    idle(1);
    check("b2b_strobes", 32'(strobeCnt - s0), 32'd2);
    check("b2b_oe_clocks", 32'(oeCnt - o0), 32'd4);
    checkArray("b2b_array");

    // Reset pulsed during TAR_H2 of a write to 0x081F
    drive(1'b0, 4'h0);
    drive(1'b1, 4'h2);
    drive(1'b1, 4'h0); drive(1'b1, 4'h8); drive(1'b1, 4'h1); drive(1'b1, 4'hF);
    drive(1'b1, 4'h7); drive(1'b1, 4'h7);
    drive(1'b1, 4'hF);
    @(negedge LpcClock);
    PciReset = 1'b0;
    #1;
    for (int i = 1; i < 32; i++) model[i] = 8'h00;
    check("midrst_oe", 32'(bus.LadOe), 32'd0);
    check("midrst_lad", 32'(bus.LadOut), 32'hF);
    check("midrst_strobe", 32'(WrStrobe), 32'd0);
    check("midrst_addr", 32'(AddrReg), 32'h00);
    check("midrst_data", 32'(DataWr), 32'h00);
    check("midrst_reg31", 32'(DataReg[31]), 32'h00);
    checkArray("midrst_array");
    @(negedge LpcClock);
    PciReset = 1'b1;
    idle(3);
    check("midrst_no_commit", 32'(DataReg[31]), 32'h00);

    ioCycle(4'h2, 16'h081F, 8'h11, 1'b1, 3);
    idle(2);
    check("w1f_reg31", 32'(DataReg[31]), 32'h11);
    checkArray("w1f_array");

    check("sb_drained", 32'(sbQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
